// File: rtl/aes128_enc_ctrl.sv
// aes128_enc_ctrl -- iterative AES-128 encryption engine.
// Takes one plaintext/key pair on a valid/ready handshake and applies the
// initial AddRoundKey. It then runs one round per clock through a shared
// round datapath: rounds 1..NR-1 are full rounds, and round NR skips
// MixColumns. Round keys are expanded on the fly from the previous round key.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready plaintext+key handshake (in_ready only in IDLE)
//   plaintext, key    128-bit inputs, byte 0 at [127:120]
//   out_valid/out_ready ciphertext handshake, held until consumed
//   ciphertext        result block (retained after consumption)
//   busy              high while rounds are in progress (ROUND/FINAL)

// One MixColumns column: {a0,a1,a2,a3} -> {b0,b1,b2,b3}.
module aes128_mix_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes128_enc_ctrl #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  localparam int         NUM_COLS = 4;
  localparam logic [3:0] LAST_RND = 4'(NR - 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] ct_q, ct_d;
  logic         out_valid_q, out_valid_d;

  // Key expansion step: the next round key is derived from the current one.
  logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [127:0] next_key;
  assign {w0, w1, w2, w3} = rkey_q;
  // SubWord(RotWord(w3)): rotate left by one byte, then substitute.
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Round datapath. Byte i sits at [127-8i]; row r, column c is byte r+4c.
  logic [127:0] sb, sr, mc;
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
  end
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // ShiftRows: row r rotates left by r columns.
      assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
    aes128_mix_col u_mix (
      .col_i(sr[127-32*c -: 32]),
      .col_o(mc[127-32*c -: 32])
    );
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    round_cnt_d = round_cnt_q;
    rcon_d      = rcon_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        state_d     = plaintext ^ key;
        rkey_d      = key;
        round_cnt_d = 4'd1;
        rcon_d      = RCON_INIT;
        fsm_d       = ROUND;
      end
      ROUND: begin
        state_d     = mc ^ next_key;
        rkey_d      = next_key;
        rcon_d      = xtime(rcon_q);
        round_cnt_d = round_cnt_q + 4'd1;
        if (round_cnt_q == LAST_RND) fsm_d = FINAL;
      end
      FINAL: begin
        // Last round has no MixColumns; result goes straight to the output.
        ct_d        = sr ^ next_key;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      round_cnt_q <= '0;
      rcon_q      <= RCON_INIT;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      round_cnt_q <= round_cnt_d;
      rcon_q      <= rcon_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (fsm_q == IDLE);
  assign busy       = (fsm_q == ROUND) || (fsm_q == FINAL);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Scoreboard bench for aes128_enc_ctrl using FIPS-197 vectors.
module tb_aes128_enc_ctrl;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] plaintext = '0, key = '0, ciphertext;

  always #5 clk = ~clk;

  aes128_enc_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  typedef struct { logic [127:0] ct; int acc; } exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, last_acc = 0;
  logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: when a new output appears, pop the oldest expectation.
  bit seen = 0;
  always @(negedge clk) begin
    if (rst || !out_valid) seen = 0;
    else if (!seen) begin
      exp_t e;
      seen = 1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_output: got %h expected none", ciphertext);
      end else begin
        e = exp_q.pop_front();
        check("ciphertext", ciphertext, e.ct);
        check("latency", 128'(cyc - e.acc), 128'd10);
      end
    end
  end

  task automatic rand_inputs();
    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key       = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("ready_timeout", 128'(ok), 128'd1);
  endtask

  // Present a block; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] ct, input bit hold);
    exp_t e;
    plaintext = pt; key = k; in_valid = 1'b1;
    wait_ready();
    e.ct = ct; e.acc = cyc + 1;
    exp_q.push_back(e);
    last_acc = e.acc;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    int a;
    bit ok;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ciphertext", ciphertext, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // App. B with round-1 key probe.
    send(PT_B, KEY_B, CT_B, 0);
    check("busy_in_round", 128'(busy), 128'd1);
    @(negedge clk);
    check("rkey_round1", dut.rkey_q, RK1_B);

    // App. C.1 with rcon sequence.
    send(PT_C, KEY_C, CT_C, 0);
    for (int i = 0; i < 10; i++) begin
      check("rcon", 128'(dut.rcon_q), 128'(rcon_exp[i]));
      @(negedge clk);
    end

    // Inputs wander after acceptance.
    send(PT_B, KEY_B, CT_B, 0);
    for (int i = 0; i < 9; i++) begin
      rand_inputs();
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Backpressure: result held for 20 cycles, new requests ignored.
    wait_ready();
    out_ready = 1'b0;
    send(PT_C, KEY_C, CT_C, 0);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check("done_timeout", 128'(ok), 128'd1);
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ciphertext", ciphertext, CT_C);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      rand_inputs();
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    check("ct_retained", ciphertext, CT_C);

    // Back-to-back with in_valid held high.
    send(PT_B, KEY_B, CT_B, 1);
    a = last_acc;
    send(PT_C, KEY_C, CT_C, 1);
    in_valid = 1'b0;
    check("b2b_period", 128'(last_acc - a), 128'd12);

    // Reset mid-operation.
    wait_ready();
    send(PT_C, KEY_C, CT_C, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (dut.round_cnt_q == 4'd5) begin ok = 1; break; end
      @(negedge clk);
    end
    check("cnt5_timeout", 128'(ok), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    send(PT_B, KEY_B, CT_B, 0);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
